filter_ds_x8_decim: RTL and testbench

- Decimation stage directly downstream of the FIR low-pass core inside FILTER_DS_x8_v3.
- Consumes the filter's AXI4-Stream I/Q output and forwards one sample in every DS_FACTOR samples, at a programmable phase.
- Generates frame tlast on the decimated stream and feeds the IP's M00 stream output.
- Configuration comes from the S00_AXI register bank: enable, phase and frame length.

---
 rtl/filter_ds_pkg.sv | 25 ++
 rtl/axis_skid_buf.sv | 58 +++++
 rtl/filter_ds_x8_decim.sv | 94 +++++++++
 tb/tb_filter_ds_x8_decim.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_ds_pkg.sv
// rtl/filter_ds_pkg.sv - shared types and constants for the FILTER_DS decimation stage
package filter_ds_pkg;

    localparam int DATA_W    = 32;
    localparam int DS_FACTOR = 8;
    localparam int PH_W      = $clog2(DS_FACTOR);
    localparam int FLEN_W    = 16;

    typedef struct packed {
        logic [DATA_W/2-1:0] i;
        logic [DATA_W/2-1:0] q;
    } sample_t;

    typedef struct packed {
        sample_t data;
        logic    last;
    } skid_entry_t;

    // A zero frame length disables tlast generation entirely.
    function automatic logic frame_end(input logic [FLEN_W-1:0] cnt,
                                       input logic [FLEN_W-1:0] flen);
        return (flen != '0) && (cnt == flen - FLEN_W'(1));
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// rtl/axis_skid_buf.sv - two-entry registered buffer with push/pop and full/empty flags
module axis_skid_buf
    import filter_ds_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_push,
    input  skid_entry_t i_push_entry,
    input  logic        i_pop,
    output skid_entry_t o_head,
    output logic        o_empty,
    output logic        o_full_next
);

    skid_entry_t r_mem [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_cnt;

    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_cnt_next;

    assign w_push = i_push && (r_cnt != 2'd2);
    assign w_pop  = i_pop && (r_cnt != 2'd0);

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_push && !w_pop) begin
            w_cnt_next = r_cnt + 2'd1;
        end else if (!w_push && w_pop) begin
            w_cnt_next = r_cnt - 2'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem    <= '{default: '0};
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt <= w_cnt_next;
        end
    end

    assign o_head      = r_mem[r_rd_ptr];
    assign o_empty     = (r_cnt == 2'd0);
    assign o_full_next = (w_cnt_next == 2'd2);

endmodule

// File: rtl/filter_ds_x8_decim.sv
// rtl/filter_ds_x8_decim.sv - keeps one I/Q sample per DS_FACTOR group and frames the decimated stream
module filter_ds_x8_decim
    import filter_ds_pkg::*;
(
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cfg_enable,
    input  logic [PH_W-1:0]   cfg_phase,
    input  logic [FLEN_W-1:0] cfg_frame_len,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [31:0]       stat_out_cnt
);

    logic              r_en_q;
    logic [PH_W-1:0]   r_phase_q;
    logic [FLEN_W-1:0] r_flen_q;
    logic [PH_W-1:0]   r_phase_cnt;
    logic [FLEN_W-1:0] r_frame_cnt;
    logic              r_s_ready;
    logic [31:0]       r_stat;

    logic              w_acc;
    logic              w_keep;
    logic              w_last;
    logic              w_pop;
    logic              w_empty;
    logic              w_full_next;
    skid_entry_t       w_entry;
    skid_entry_t       w_head;

    // r_en_q doubles as the "enabled" qualifier: keeps start the cycle after the
    // config is latched and stop the cycle after cfg_enable falls.
    assign w_acc   = s_axis_tvalid && r_s_ready;
    assign w_keep  = r_en_q && w_acc && (r_phase_cnt == r_phase_q);
    assign w_last  = frame_end(r_frame_cnt, r_flen_q);
    assign w_pop   = m_axis_tvalid && m_axis_tready;
    assign w_entry = '{data: sample_t'(s_axis_tdata), last: w_last};

    axis_skid_buf u_skid (
        .i_clk        (ACLK),
        .i_rst        (ARESET),
        .i_push       (w_keep),
        .i_push_entry (w_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_empty      (w_empty),
        .o_full_next  (w_full_next)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_en_q      <= 1'b0;
            r_phase_q   <= '0;
            r_flen_q    <= '0;
            r_phase_cnt <= '0;
            r_frame_cnt <= '0;
            r_s_ready   <= 1'b0;
            r_stat      <= '0;
        end else begin
            r_en_q    <= cfg_enable;
            r_s_ready <= !w_full_next;
            if (cfg_enable && !r_en_q) begin
                r_phase_q <= cfg_phase;
                r_flen_q  <= cfg_frame_len;
            end
            if (!cfg_enable) begin
                r_phase_cnt <= '0;
                r_frame_cnt <= '0;
            end else if (r_en_q && w_acc) begin
                r_phase_cnt <= s_axis_tlast ? '0 : r_phase_cnt + PH_W'(1);
                if (w_keep) begin
                    r_frame_cnt <= w_last ? '0 : r_frame_cnt + FLEN_W'(1);
                end
            end
            if (w_pop) begin
                r_stat <= r_stat + 32'd1;
            end
        end
    end

    assign s_axis_tready = r_s_ready;
    assign m_axis_tvalid = !w_empty;
    assign m_axis_tdata  = w_head.data;
    assign m_axis_tlast  = w_head.last;
    assign stat_out_cnt  = r_stat;

endmodule

// File: tb/tb_filter_ds_x8_decim.sv
// tb/tb_filter_ds_x8_decim.sv - randomized and directed self-checking bench for filter_ds_x8_decim
module tb_filter_ds_x8_decim;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cfg_enable;
    logic [2:0]  cfg_phase;
    logic [15:0] cfg_frame_len;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [31:0] stat_out_cnt;

    always #5 ACLK = ~ACLK;

    filter_ds_x8_decim dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .cfg_enable    (cfg_enable),
        .cfg_phase     (cfg_phase),
        .cfg_frame_len (cfg_frame_len),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .stat_out_cnt  (stat_out_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] d;
        bit          l;
    } ent_t;

    ent_t        mq[$];
    bit          m_en_q, m_rdy;
    int          m_ph, m_fc, m_phq, m_flq;
    logic [31:0] m_stat;

    logic [31:0] log_d[$];
    bit          log_l[$];

    bit          d_rst, d_en, d_valid, d_last, d_mready;
    int          d_phase, d_flen;
    logic [31:0] d_data;
    bit          last_acc, rnd_ready, saw_stall;
    int          stall_left;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_en_q = 0; m_rdy = 0; m_ph = 0; m_fc = 0; m_phq = 0; m_flq = 0; m_stat = '0;
    endtask

    task automatic check_outputs();
        chk("m_tvalid", m_axis_tvalid, mq.size() > 0);
        chk("s_tready", s_axis_tready, m_rdy);
        chk("stat_out_cnt", stat_out_cnt, m_stat);
        if (mq.size() > 0) begin
            chk("m_tdata", m_axis_tdata, mq[0].d);
            chk("m_tlast", m_axis_tlast, mq[0].l);
        end
        if (d_rst) begin
            chk("rst_tdata", m_axis_tdata, 0);
            chk("rst_tlast", m_axis_tlast, 0);
        end
    endtask

    // One clock: drive inputs, advance the reference, then compare after the edge.
    task automatic step();
        bit   acc, keep, pop, lst;
        ent_t e;
        if (stall_left > 0) begin
            d_mready = 0;
            stall_left--;
        end else if (rnd_ready) begin
            d_mready = ($urandom_range(0, 3) != 0);
        end else begin
            d_mready = 1;
        end
        ARESET = d_rst; cfg_enable = d_en; cfg_phase = 3'(d_phase); cfg_frame_len = 16'(d_flen);
        s_axis_tvalid = d_valid; s_axis_tdata = d_data; s_axis_tlast = d_last; m_axis_tready = d_mready;
        if (!d_rst && m_axis_tvalid && d_mready) begin
            log_d.push_back(m_axis_tdata);
            log_l.push_back(m_axis_tlast);
        end
        if (!d_rst && !s_axis_tready) saw_stall = 1;
        acc = d_valid && m_rdy && !d_rst;
        last_acc = acc;
        if (d_rst) begin
            model_reset();
        end else begin
            pop  = (mq.size() > 0) && d_mready;
            keep = m_en_q && acc && (m_ph == m_phq);
            lst  = (m_flq != 0) && (m_fc == m_flq - 1);
            if (pop) begin
                e = mq.pop_front();
                m_stat++;
            end
            if (keep) begin
                e.d = d_data; e.l = lst;
                mq.push_back(e);
            end
            if (!d_en) begin
                m_ph = 0; m_fc = 0;
            end else if (m_en_q && acc) begin
                m_ph = d_last ? 0 : (m_ph + 1) % 8;
                if (keep) m_fc = lst ? 0 : m_fc + 1;
            end
            if (d_en && !m_en_q) begin
                m_phq = d_phase; m_flq = d_flen;
            end
            m_en_q = d_en;
            m_rdy  = (mq.size() < 2);
        end
        @(posedge ACLK);
        @(negedge ACLK);
        check_outputs();
    endtask

    task automatic idle(input int n);
        d_valid = 0; d_last = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic enable(input int ph, input int fl);
        d_valid = 0; d_last = 0; d_en = 0;
        step();
        d_phase = ph; d_flen = fl; d_en = 1;
        step();
    endtask

    task automatic stream(input int first, input int n, input int tlast_idx, input int budget);
        int idx = first;
        int cyc = 0;
        while (idx < first + n && cyc < budget) begin
            d_valid = 1; d_data = 32'(idx); d_last = (idx == tlast_idx);
            step();
            if (last_acc) idx++;
            cyc++;
        end
        d_valid = 0; d_last = 0;
        chk("stream_done", idx, first + n);
    endtask

    function automatic int count_lasts();
        int c = 0;
        foreach (log_l[i]) c += log_l[i];
        return c;
    endfunction

    initial begin
        d_rst = 1; d_en = 0; d_valid = 0; d_last = 0; d_mready = 1;
        d_phase = 0; d_flen = 0; d_data = '0; rnd_ready = 0; stall_left = 0;
        ARESET = 1; cfg_enable = 0; cfg_phase = 0; cfg_frame_len = 0;
        s_axis_tvalid = 0; s_axis_tdata = 0; s_axis_tlast = 0; m_axis_tready = 1;
        model_reset();
        @(negedge ACLK);
        step(); step();
        d_rst = 0;
        step();

        enable(0, 0);
        log_d.delete(); log_l.delete();
        stream(0, 64, -1, 400);
        idle(4);
        chk("p0_count", log_d.size(), 8);
        chk("p0_second", log_d[1], 8);
        chk("p0_last", log_d[7], 56);
        chk("p0_no_tlast", count_lasts(), 0);
        chk("p0_stat", stat_out_cnt, 8);

        enable(5, 4);
        log_d.delete(); log_l.delete();
        stream(0, 128, -1, 600);
        idle(4);
        chk("p5_count", log_d.size(), 16);
        chk("p5_first", log_d[0], 5);
        chk("p5_frame_end", log_d[3], 29);
        chk("p5_tlast3", log_l[3], 1);
        chk("p5_tlast2", log_l[2], 0);
        chk("p5_final", log_d[15], 125);
        chk("p5_tlast15", log_l[15], 1);
        chk("p5_lasts", count_lasts(), 4);

        enable(3, 0);
        log_d.delete(); log_l.delete();
        stream(0, 31, 10, 300);
        idle(4);
        chk("resync_count", log_d.size(), 4);
        chk("resync_0", log_d[0], 3);
        chk("resync_1", log_d[1], 14);
        chk("resync_2", log_d[2], 22);

        enable(0, 0);
        log_d.delete(); log_l.delete();
        saw_stall = 0;
        stall_left = 40;
        stream(0, 64, -1, 1000);
        idle(4);
        chk("stall_backpressure", saw_stall, 1);
        chk("stall_count", log_d.size(), 8);
        for (int i = 0; i < 8; i++) chk("stall_seq", log_d[i], 32'(8 * i));

        enable(0, 0);
        log_d.delete(); log_l.delete();
        stall_left = 1000;
        stream(0, 9, -1, 100);
        step();
        chk("dis_full_tready", s_axis_tready, 0);
        d_en = 0; d_valid = 1; d_data = 32'd500;
        step(); step(); step();
        stall_left = 0;
        stream(20, 30, -1, 200);
        idle(4);
        chk("dis_drain_count", log_d.size(), 2);
        chk("dis_drain_0", log_d[0], 0);
        chk("dis_drain_1", log_d[1], 8);
        enable(7, 0);
        log_d.delete(); log_l.delete();
        stream(100, 16, -1, 200);
        idle(4);
        chk("reen_first", log_d[0], 107);
        chk("reen_count", log_d.size(), 2);

        rnd_ready = 1;
        enable($urandom_range(0, 7), $urandom_range(0, 5));
        for (int i = 0; i < 800; i++) begin
            d_valid = ($urandom_range(0, 3) != 0);
            d_data  = $urandom;
            d_last  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) begin
                d_en = !d_en;
                d_phase = $urandom_range(0, 7);
                d_flen  = $urandom_range(0, 5);
            end
            step();
        end
        rnd_ready = 0;
        idle(4);

        enable(0, 0);
        stall_left = 1000;
        stream(0, 9, -1, 100);
        #2;
        ARESET = 1;
        #1;
        chk("async_rst_tvalid", m_axis_tvalid, 0);
        chk("async_rst_stat", stat_out_cnt, 0);
        chk("async_rst_tready", s_axis_tready, 0);
        d_rst = 1; stall_left = 0;
        step(); step();
        d_rst = 0;
        step();
        chk("post_rst_idle", m_axis_tvalid, 0);
        enable(2, 3);
        log_d.delete(); log_l.delete();
        stream(0, 40, -1, 300);
        idle(4);
        chk("post_rst_count", log_d.size(), 5);
        chk("post_rst_frame", log_d[2], 18);
        chk("post_rst_tlast", log_l[2], 1);
        chk("post_rst_stat", stat_out_cnt, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
